// File: rtl/complex_result_streamer.sv
// Streams a captured ROWS x COLS complex result matrix one element per beat,
// row-major, with row/column tags, an end-of-matrix flag and an overrun pulse.
module complex_result_streamer #(
    parameter  int ROWS = 2,
    parameter  int COLS = 2,
    parameter  int SIZE = 16,
    localparam int EW   = 3 * SIZE,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [ROWS*COLS*EW-1:0]  in_result,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [EW-1:0]            out_data,
    output logic [RW-1:0]            out_row,
    output logic [CW-1:0]            out_col,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    state_e                    state_q, state_d;
    logic   [RW-1:0]           row_q, row_d;
    logic   [CW-1:0]           col_q, col_d;
    logic   [EW-1:0]           data_q, data_d;
    logic                      last_q, last_d;
    logic                      overrun_q, overrun_d;
    logic   [ROWS*COLS*EW-1:0] buf_q, buf_d;
    logic                      capture;
    logic                      xfer;
    logic                      at_last;

    assign xfer    = (state_q == SEND) && out_ready;
    assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            data_q    <= data_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the matrix buffer has no reset; its contents are never observed before a capture.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = SEND;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (at_last) begin
                        row_d = '0;
                        col_d = '0;
                        // A new matrix arriving on the final handshake chains with no bubble.
                        if (in_valid) capture = 1'b1;
                        else          state_d = IDLE;
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded with the element the next cycle will present.
    always_comb begin
        int idx;
        buf_d     = capture ? in_result : buf_q;
        idx       = int'(row_d) * COLS + int'(col_d);
        data_d    = '0;
        last_d    = 1'b0;
        if (state_d == SEND) begin
            data_d = buf_d[idx*EW +: EW];
            last_d = (row_d == ROW_MAX) && (col_d == COL_MAX);
        end
        overrun_d = in_valid && (state_q == SEND) && !capture;
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign overrun   = overrun_q;

endmodule
